// File: rtl/servo_ramp.sv
// servo_ramp - rate-limited position ramp for a hobby-servo PWM generator.
//
// A free-running frame counter marks the last cycle of every PWM frame with
// frame_tick. Accepted target commands are clamped into [MIN_POS, MAX_POS]
// and pos_out walks toward the target by at most MAX_STEP per frame, so
// the servo never sees a jump larger than the mechanical slew limit.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   target command present
//   cmd_pos    in   requested target position (POS_W bits, unsigned)
//   cmd_ready  out  command accepted on an edge where cmd_valid is also high
//   pos_out    out  current position for the downstream PWM generator
//   frame_tick out  one-cycle pulse on the last cycle of each frame
//   busy       out  high while ramping
//   at_target  out  high when pos_out equals the stored target
//
// Configuration macro:
//   SERVO_RAMP_PREEMPT_EN  when defined, commands are accepted during a ramp
//                          and retarget it in flight (including reversal);
//                          when undefined, commands are only taken in IDLE.

module servo_ramp #(
    parameter int CLK_FREQ  = 50000000,
    parameter int PERIOD    = 1000000,
    parameter int POS_W     = 8,
    parameter int MIN_POS   = 0,
    parameter int MAX_POS   = 255,
    parameter int RESET_POS = 0,
    parameter int MAX_STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [POS_W-1:0] cmd_pos,
    output logic             cmd_ready,
    output logic [POS_W-1:0] pos_out,
    output logic             frame_tick,
    output logic             busy,
    output logic             at_target
);

    localparam int               CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [POS_W-1:0] MIN_L    = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0] MAX_L    = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] RESET_L  = POS_W'(RESET_POS);
    // A step can never usefully exceed the full position span, so cap it
    // before narrowing to the POS_W+1 bit step datapath.
    localparam int               STEP_CAP = (MAX_STEP > (1 << POS_W)) ? (1 << POS_W) : MAX_STEP;
    localparam logic [POS_W:0]   STEP_L   = (POS_W + 1)'(STEP_CAP);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] target_next;
    logic [POS_W-1:0] cmd_clamped;
    logic [POS_W-1:0] pos_next;
    logic [POS_W:0]   pos_ext;
    logic [POS_W:0]   tgt_ext;
    logic [POS_W:0]   diff;
    logic [POS_W:0]   step_amt;
    logic [POS_W:0]   pos_sum;
    logic             accept;
    logic             ready_next;

    always_comb begin
        cnt_next    = (frame_cnt == LAST_CNT) ? '0 : frame_cnt + 1'b1;
        accept      = cmd_valid && cmd_ready;

        cmd_clamped = cmd_pos;
        if (cmd_pos < MIN_L) begin
            cmd_clamped = MIN_L;
        end else if (cmd_pos > MAX_L) begin
            cmd_clamped = MAX_L;
        end

        // Distance is computed one bit wider than the position so neither
        // the subtraction nor the add/sub of the step can wrap; limiting the
        // step to the remaining distance prevents overshoot.
        pos_ext  = {1'b0, pos_out};
        tgt_ext  = {1'b0, target};
        diff     = (tgt_ext > pos_ext) ? (tgt_ext - pos_ext) : (pos_ext - tgt_ext);
        step_amt = (diff > STEP_L) ? STEP_L : diff;
        pos_sum  = pos_ext;
        if (state == RAMP && frame_tick) begin
            pos_sum = (tgt_ext > pos_ext) ? (pos_ext + step_amt) : (pos_ext - step_amt);
        end
        pos_next = pos_sum[POS_W-1:0];

        // The step above always uses the old target; a command landing in
        // the same tick cycle only takes effect from the next frame, and the
        // state decision compares it against the already-stepped position.
        target_next = target;
        state_next  = state;
        if (accept) begin
            target_next = cmd_clamped;
            state_next  = (cmd_clamped != pos_next) ? RAMP : IDLE;
        end else if (state == RAMP && pos_next == target) begin
            state_next = IDLE;
        end

`ifdef SERVO_RAMP_PREEMPT_EN
        ready_next = 1'b1;
`else
        ready_next = (state_next == IDLE);
`endif
    end

    // All outputs are registered from the next-state values so busy and
    // at_target line up exactly with state and pos_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            pos_out    <= RESET_L;
            target     <= RESET_L;
            busy       <= 1'b0;
            at_target  <= 1'b1;
            cmd_ready  <= 1'b0;
        end else begin
            state      <= state_next;
            frame_cnt  <= cnt_next;
            frame_tick <= (cnt_next == LAST_CNT);
            pos_out    <= pos_next;
            target     <= target_next;
            busy       <= (state_next == RAMP);
            at_target  <= (pos_next == target_next);
            cmd_ready  <= ready_next;
        end
    end

endmodule

// File: tb/tb_servo_ramp.sv
// tb_servo_ramp - directed self-checking bench for servo_ramp.
//
// Uses PERIOD=4, POS_W=8, MIN_POS=10, MAX_POS=200, RESET_POS=10, MAX_STEP=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Builds with or without SERVO_RAMP_PREEMPT_EN; the retarget scenario picks
// its expectations from the same macro.

module tb_servo_ramp;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_pos;
    logic       cmd_ready;
    logic [7:0] pos_out;
    logic       frame_tick;
    logic       busy;
    logic       at_target;

    int vectors    = 0;
    int miscompares = 0;
    int steps;

    servo_ramp #(
        .CLK_FREQ (50000000),
        .PERIOD   (4),
        .POS_W    (8),
        .MIN_POS  (10),
        .MAX_POS  (200),
        .RESET_POS(10),
        .MAX_STEP (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_pos   (cmd_pos),
        .cmd_ready (cmd_ready),
        .pos_out   (pos_out),
        .frame_tick(frame_tick),
        .busy      (busy),
        .at_target (at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] pos);
        cmd_valid = valid;
        cmd_pos   = pos;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to the edge that closes the next frame_tick cycle (the only
    // edge where pos_out may move), with a bounded wait for the tick.
    task automatic finishFrame();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checkOutput("frame_tick_reached", {31'd0, frame_tick}, 32'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 8'd0);
        repeat (3) tick();

        // Reset state
        checkOutput("rst_pos_out",    32'(pos_out),    32'd10);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_at_target",  32'(at_target),  32'd1);
        checkOutput("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        checkOutput("rst_frame_tick", 32'(frame_tick), 32'd0);

        // Release: ready after first edge, tick on 4th cycle, then every 4
        rst = 1'b0;
        tick();
        checkOutput("rel_cmd_ready",  32'(cmd_ready),  32'd1);
        checkOutput("rel_tick_c2",    32'(frame_tick), 32'd0);
        tick();
        checkOutput("rel_tick_c3",    32'(frame_tick), 32'd0);
        tick();
        checkOutput("rel_tick_c4",    32'(frame_tick), 32'd1);
        checkOutput("rel_pos_out",    32'(pos_out),    32'd10);
        tick();
        checkOutput("rel_tick_c5",    32'(frame_tick), 32'd0);
        tick();
        tick();
        checkOutput("rel_tick_c7",    32'(frame_tick), 32'd0);
        tick();
        checkOutput("rel_tick_c8",    32'(frame_tick), 32'd1);

        // Small ramp 10 -> 15: 12, 14, 15 (command lands in a tick cycle)
        applyStimulus(1'b1, 8'd15);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("r15_busy",       32'(busy),       32'd1);
        checkOutput("r15_cmd_ready",  32'(cmd_ready),  32'd0);
        checkOutput("r15_at_target",  32'(at_target),  32'd0);
        checkOutput("r15_pos_hold",   32'(pos_out),    32'd10);
        tick();
        checkOutput("r15_pos_midfr",  32'(pos_out),    32'd10);
        finishFrame();
        checkOutput("r15_step1",      32'(pos_out),    32'd12);
        finishFrame();
        checkOutput("r15_step2",      32'(pos_out),    32'd14);
        checkOutput("r15_busy_mid",   32'(busy),       32'd1);
        finishFrame();
        checkOutput("r15_step3",      32'(pos_out),    32'd15);
        checkOutput("r15_busy_end",   32'(busy),       32'd0);
        checkOutput("r15_at_tgt_end", 32'(at_target),  32'd1);
        checkOutput("r15_ready_end",  32'(cmd_ready),  32'd1);

        // Clamp high: 250 -> 200, 185 apart = 92 steps of 2 plus one of 1
        applyStimulus(1'b1, 8'd250);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("hi_busy",        32'(busy),       32'd1);
        finishFrame();
        checkOutput("hi_first_step",  32'(pos_out),    32'd17);
        steps = 1;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            finishFrame();
            steps++;
        end
        checkOutput("hi_steps",       32'(steps),      32'd93);
        checkOutput("hi_pos_end",     32'(pos_out),    32'd200);
        checkOutput("hi_busy_end",    32'(busy),       32'd0);
        checkOutput("hi_at_target",   32'(at_target),  32'd1);

        // Clamp low: 3 -> 10, 190 apart = 95 steps
        applyStimulus(1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0);
        steps = 0;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            finishFrame();
            steps++;
        end
        checkOutput("lo_steps",       32'(steps),      32'd95);
        checkOutput("lo_pos_end",     32'(pos_out),    32'd10);
        checkOutput("lo_at_target",   32'(at_target),  32'd1);

        // Equal target: no ramp
        applyStimulus(1'b1, 8'd10);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("eq_busy",        32'(busy),       32'd0);
        checkOutput("eq_at_target",   32'(at_target),  32'd1);
        checkOutput("eq_cmd_ready",   32'(cmd_ready),  32'd1);
        finishFrame();
        finishFrame();
        checkOutput("eq_pos_hold",    32'(pos_out),    32'd10);
        checkOutput("eq_busy_later",  32'(busy),       32'd0);

        // Retarget: 100 accepted, then 12 after two steps at pos 14
        applyStimulus(1'b1, 8'd100);
        tick();
        applyStimulus(1'b0, 8'd0);
        finishFrame();
        finishFrame();
        checkOutput("rt_pos_14",      32'(pos_out),    32'd14);
`ifdef SERVO_RAMP_PREEMPT_EN
        checkOutput("rt_ready_ramp",  32'(cmd_ready),  32'd1);
        applyStimulus(1'b1, 8'd12);
        tick();
        applyStimulus(1'b0, 8'd0);
        checkOutput("rt_busy_retgt",  32'(busy),       32'd1);
        checkOutput("rt_pos_hold",    32'(pos_out),    32'd14);
        finishFrame();
        checkOutput("rt_pos_12",      32'(pos_out),    32'd12);
        checkOutput("rt_busy_end",    32'(busy),       32'd0);
        checkOutput("rt_at_target",   32'(at_target),  32'd1);
        finishFrame();
        checkOutput("rt_pos_stays",   32'(pos_out),    32'd12);
`else
        checkOutput("rt_ready_ramp",  32'(cmd_ready),  32'd0);
        applyStimulus(1'b1, 8'd12);
        finishFrame();
        applyStimulus(1'b0, 8'd0);
        checkOutput("rt_pos_16",      32'(pos_out),    32'd16);
        checkOutput("rt_busy_kept",   32'(busy),       32'd1);
        steps = 0;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            finishFrame();
            steps++;
        end
        checkOutput("rt_steps_rest",  32'(steps),      32'd42);
        checkOutput("rt_pos_100",     32'(pos_out),    32'd100);
        checkOutput("rt_at_target",   32'(at_target),  32'd1);
`endif

        // Park at 30, then ramp up toward 60 and reset at pos 40
        applyStimulus(1'b1, 8'd30);
        tick();
        applyStimulus(1'b0, 8'd0);
        for (int i = 0; i < 300 && busy === 1'b1; i++) finishFrame();
        checkOutput("park_pos_30",    32'(pos_out),    32'd30);
        applyStimulus(1'b1, 8'd60);
        tick();
        applyStimulus(1'b0, 8'd0);
        for (int i = 0; i < 20 && pos_out !== 8'd40; i++) finishFrame();
        checkOutput("mid_pos_40",     32'(pos_out),    32'd40);
        checkOutput("mid_busy",       32'(busy),       32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_pos_out",     32'(pos_out),    32'd10);
        checkOutput("mr_busy",        32'(busy),       32'd0);
        checkOutput("mr_at_target",   32'(at_target),  32'd1);
        checkOutput("mr_cmd_ready",   32'(cmd_ready),  32'd0);
        checkOutput("mr_frame_tick",  32'(frame_tick), 32'd0);
        repeat (3) finishFrame();
        checkOutput("mr_pos_frozen",  32'(pos_out),    32'd10);
        checkOutput("mr_busy_later",  32'(busy),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
SERVO_RAMP -- requirements
Module: servo_ramp

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock cycles per second (informational; no logic depends on it).
REQ-002 SHALL have parameter PERIOD, default 1000000, clock cycles per PWM frame; legal values are at least 2.
REQ-003 SHALL have parameter POS_W, default 8, position width in bits.
REQ-004 SHALL have parameters MIN_POS, default 0, and MAX_POS, default 255, the legal position range; MIN_POS <= MAX_POS.
REQ-005 SHALL have parameter RESET_POS, default 0, the position loaded at reset; MIN_POS <= RESET_POS <= MAX_POS.
REQ-006 SHALL have parameter MAX_STEP, default 1, the largest position change per frame; MAX_STEP >= 1.
REQ-007 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port: rst  input  1  reset; synchronous to clk, active-high.
REQ-009 SHALL have port: cmd_valid  input  1  target position command present.
REQ-010 SHALL have port: cmd_pos  input  POS_W  requested target position, unsigned.
REQ-011 SHALL have port: cmd_ready  output  1  block accepts a command this cycle.
REQ-012 SHALL have port: pos_out  output  POS_W  current position, fed to the downstream servo PWM generator.
REQ-013 SHALL have port: frame_tick  output  1  one-cycle pulse marking the last cycle of each frame.
REQ-014 SHALL have port: busy  output  1  high while in RAMP.
REQ-015 SHALL have port: at_target  output  1  high when pos_out equals the current target.

Function
REQ-016 SHALL run a frame counter that counts 0..PERIOD-1 and wraps to 0; frame_tick is registered and high exactly while the counter equals PERIOD-1.
REQ-017 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both high.
REQ-018 SHALL saturate the accepted cmd_pos to [MIN_POS, MAX_POS] before storing it as target.
REQ-019 SHALL have a two-state FSM: IDLE and RAMP.
REQ-020 IDLE -> RAMP SHALL occur on the edge after a command is accepted whose clamped target differs from pos_out; an equal target SHALL leave the FSM in IDLE.
REQ-021 In RAMP, on each frame_tick cycle, SHALL move pos_out toward target by min(MAX_STEP, |target - pos_out|); pos_out SHALL change only on the edge ending a frame_tick cycle.
REQ-022 RAMP -> IDLE SHALL occur on the same edge on which pos_out reaches target.
REQ-023 Step arithmetic SHALL use POS_W+1 bits; there SHALL be no wrap-around or overshoot past target.
REQ-024 On a command accepted in a frame_tick cycle, that frame's step SHALL use the old target; the new target SHALL apply from the next frame.
REQ-025 busy SHALL equal (state == RAMP); at_target SHALL equal (pos_out == target); both are registered.

Reset
REQ-026 While rst is high, on each edge: pos_out = RESET_POS, target = RESET_POS, FSM = IDLE, frame counter = 0, frame_tick = 0, busy = 0, at_target = 1, cmd_ready = 0.
REQ-027 cmd_ready SHALL rise on the first edge with rst low.
REQ-028 Reset asserted mid-ramp SHALL abandon the ramp with no further position steps.

Configuration
REQ-029 The macro SERVO_RAMP_PREEMPT_EN controls preemption. When defined, cmd_ready = 1 in both IDLE and RAMP, and a new command retargets the ramp in flight, including reversing direction.
REQ-030 When SERVO_RAMP_PREEMPT_EN is undefined, cmd_ready = 1 only in IDLE and 0 in RAMP, and commands presented during RAMP are ignored.

Verification
Bench parameters: PERIOD=4, POS_W=8, MIN_POS=10, MAX_POS=200, RESET_POS=10, MAX_STEP=2.
REQ-031 Reset, then release -> pos_out=10, at_target=1, busy=0, cmd_ready=1 one cycle after release, frame_tick high on the 4th cycle after release and every 4 cycles thereafter.
REQ-032 cmd_pos=15 accepted -> busy=1 next cycle; pos_out steps 12, 14, 15 on three successive frame_ticks; then busy=0, at_target=1.
REQ-033 cmd_pos=250 -> target clamped to 200, ramp ends at 200. Then cmd_pos=3 -> target 10, ramp ends at 10.
REQ-034 cmd_pos=10 while pos_out=10 -> no RAMP entry, busy stays 0, pos_out unchanged.
REQ-035 cmd_pos=100 accepted, then cmd_pos=12 after two steps (pos_out=14). With SERVO_RAMP_PREEMPT_EN defined -> pos_out goes 14, 12 and stops. Without it -> cmd_ready=0 in RAMP, second command ignored, ramp completes to 100.
REQ-036 rst asserted for one cycle while pos_out=40 in RAMP -> next edge pos_out=10, busy=0, and no further steps.
